// File: rtl/zap_predecode_copro_mux_pkg.sv
`default_nettype none
// zap_predecode_copro_mux_pkg -- opcode patterns, CPU mode encodings and dispatch FSM states.
// Revision: 1.0
package zap_predecode_copro_mux_pkg;

  localparam int unsigned NUM_CP = 16;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  // Condition field is left out of every mask, so the *2 forms (cond=1111) match too.
  localparam logic [31:0] MSK_CDP = 32'h0F00_0010;
  localparam logic [31:0] PAT_CDP = 32'h0E00_0000;
  localparam logic [31:0] MSK_MCR = 32'h0F10_0010;
  localparam logic [31:0] PAT_MCR = 32'h0E00_0010;
  localparam logic [31:0] PAT_MRC = 32'h0E10_0010;
  localparam logic [31:0] MSK_LDC = 32'h0E10_0000;
  localparam logic [31:0] PAT_STC = 32'h0C00_0000;
  localparam logic [31:0] PAT_LDC = 32'h0C10_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TRAP = 2'd2
  } copro_state_t;

  function automatic logic is_copro_op(input logic [31:0] w);
    is_copro_op = ((w & MSK_CDP) == PAT_CDP) ||
                  ((w & MSK_MCR) == PAT_MCR) ||
                  ((w & MSK_MCR) == PAT_MRC) ||
                  ((w & MSK_LDC) == PAT_STC) ||
                  ((w & MSK_LDC) == PAT_LDC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/zap_copro_timeout_ctr.sv
`default_nettype none
// zap_copro_timeout_ctr -- loadable down-counter with freeze, clear and zero flag.
// Revision: 1.0
module zap_copro_timeout_ctr #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_load) begin
      count_d = i_load_value;
    end else if (i_dec && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/zap_predecode_copro_mux.sv
`default_nettype none
// zap_predecode_copro_mux -- routes coprocessor instructions to one of 16 coprocessors,
// trapping absent, forbidden or timed-out accesses as undefined. Revision: 1.0
module zap_predecode_copro_mux
  import zap_predecode_copro_mux_pkg::*;
#(
  parameter logic [15:0] CP_PRESENT_MASK = 16'h8000,
  parameter logic [15:0] CP_USR_MASK     = 16'h0000,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [34:0] i_instruction,
  input  logic        i_valid,
  input  logic        i_cpsr_ff_t,
  input  logic [4:0]  i_cpsr_ff_mode,
  input  logic        i_irq,
  input  logic        i_fiq,
  input  logic        i_clear_from_writeback,
  input  logic        i_clear_from_alu,
  input  logic        i_clear_from_decode,
  input  logic        i_data_stall,
  input  logic        i_stall_from_shifter,
  input  logic        i_stall_from_issue,
  input  logic        i_pipeline_dav,
  input  logic [15:0] i_copro_done,
  output logic [34:0] o_instruction,
  output logic        o_valid,
  output logic        o_und,
  output logic        o_irq,
  output logic        o_fiq,
  output logic        o_stall_from_decode,
  output logic [15:0] o_copro_dav_nxt,
  output logic [31:0] o_copro_word_nxt,
  output logic        o_copro_timeout
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  copro_state_t state_q, state_d;
  logic [15:0]  dav_q, dav_d;
  logic [31:0]  word_q, word_d;
  logic         timeout_q, timeout_d;

  logic         cnt_clear, cnt_load, cnt_dec, cnt_zero;
  logic         w_ext_stall, w_adv, w_flush;
  logic         w_match, w_legal, w_done, w_mask_int;
  logic [3:0]   w_cp;

  assign w_ext_stall = i_data_stall | i_stall_from_shifter | i_stall_from_issue;
  assign w_adv       = ~w_ext_stall;
  assign w_flush     = i_clear_from_writeback
                     | (i_clear_from_alu & ~i_data_stall)
                     | (i_clear_from_decode & ~w_ext_stall);

  assign w_cp    = i_instruction[11:8];
  assign w_match = i_valid && !i_cpsr_ff_t && (i_instruction[34:32] == 3'b000)
                && is_copro_op(i_instruction[31:0]);
  assign w_legal = CP_PRESENT_MASK[w_cp] && ((i_cpsr_ff_mode != MODE_USR) || CP_USR_MASK[w_cp]);
  // Only the coprocessor latched into dav may complete the request.
  assign w_done  = |(i_copro_done & dav_q);

  always_comb begin
    state_d             = state_q;
    dav_d               = dav_q;
    word_d              = word_q;
    timeout_d           = 1'b0;
    cnt_clear           = 1'b0;
    cnt_load            = 1'b0;
    cnt_dec             = 1'b0;
    o_stall_from_decode = 1'b0;
    o_und               = 1'b0;
    w_mask_int          = 1'b0;

    case (state_q)
      IDLE: begin
        if (w_match) begin
          o_stall_from_decode = 1'b1;
          w_mask_int          = 1'b1;
          if (!w_legal) begin
            state_d = TRAP;
          end else if (!i_pipeline_dav) begin
            state_d  = BUSY;
            dav_d    = 16'h0001 << w_cp;
            word_d   = i_instruction[31:0];
            cnt_load = 1'b1;
          end
        end
      end
      BUSY: begin
        o_stall_from_decode = 1'b1;
        w_mask_int          = 1'b1;
        if (w_adv && w_done) begin
          o_stall_from_decode = 1'b0;
          dav_d               = '0;
          word_d              = '0;
          state_d             = IDLE;
        end else if (w_adv && cnt_zero) begin
          timeout_d = 1'b1;
          dav_d     = '0;
          state_d   = TRAP;
        end else begin
          cnt_dec = w_adv;
        end
      end
      TRAP: begin
        o_und      = 1'b1;
        w_mask_int = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (w_flush) begin
      state_d             = IDLE;
      dav_d               = '0;
      word_d              = word_q;
      timeout_d           = 1'b0;
      cnt_clear           = 1'b1;
      cnt_load            = 1'b0;
      cnt_dec             = 1'b0;
      o_stall_from_decode = 1'b0;
      o_und               = 1'b0;
    end else if (w_ext_stall) begin
      state_d   = state_q;
      dav_d     = dav_q;
      word_d    = word_q;
      timeout_d = 1'b0;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
    end

    // Keep reset-time outputs at their reset values even before the first edge.
    if (!i_reset_n) begin
      dav_d               = '0;
      word_d              = '0;
      o_stall_from_decode = 1'b0;
      o_und               = 1'b0;
      w_mask_int          = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      dav_q     <= '0;
      word_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dav_q     <= dav_d;
      word_q    <= word_d;
      timeout_q <= timeout_d;
    end
  end

  zap_copro_timeout_ctr #(
    .WIDTH (CNT_W)
  ) u_timeout_ctr (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_clear      (cnt_clear),
    .i_load       (cnt_load),
    .i_load_value (CNT_LOAD),
    .i_dec        (cnt_dec),
    .o_zero       (cnt_zero)
  );

  assign o_instruction    = i_instruction;
  assign o_valid          = i_valid;
  assign o_irq            = i_irq & ~w_mask_int;
  assign o_fiq            = i_fiq & ~w_mask_int;
  assign o_copro_dav_nxt  = dav_d;
  assign o_copro_word_nxt = word_d;
  assign o_copro_timeout  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_zap_predecode_copro_mux.sv
`default_nettype none
// tb_zap_predecode_copro_mux -- directed and random stimulus against a transaction-level model.
// Revision: 1.0
module tb_zap_predecode_copro_mux;

  localparam logic [15:0] PRESENT = 16'hA005;
  localparam logic [15:0] USRM    = 16'h2001;
  localparam int          TO      = 4;
  localparam logic [4:0]  USR     = 5'b10000;
  localparam logic [4:0]  SVC     = 5'b10011;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [34:0] i_instruction;
  logic        i_valid, i_cpsr_ff_t;
  logic [4:0]  i_cpsr_ff_mode;
  logic        i_irq, i_fiq;
  logic        i_clear_from_writeback, i_clear_from_alu, i_clear_from_decode;
  logic        i_data_stall, i_stall_from_shifter, i_stall_from_issue;
  logic        i_pipeline_dav;
  logic [15:0] i_copro_done;
  logic [34:0] o_instruction;
  logic        o_valid, o_und, o_irq, o_fiq, o_stall_from_decode, o_copro_timeout;
  logic [15:0] o_copro_dav_nxt;
  logic [31:0] o_copro_word_nxt;

  zap_predecode_copro_mux #(
    .CP_PRESENT_MASK (PRESENT),
    .CP_USR_MASK     (USRM),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .i_clk                  (i_clk),
    .i_reset_n              (i_reset_n),
    .i_instruction          (i_instruction),
    .i_valid                (i_valid),
    .i_cpsr_ff_t            (i_cpsr_ff_t),
    .i_cpsr_ff_mode         (i_cpsr_ff_mode),
    .i_irq                  (i_irq),
    .i_fiq                  (i_fiq),
    .i_clear_from_writeback (i_clear_from_writeback),
    .i_clear_from_alu       (i_clear_from_alu),
    .i_clear_from_decode    (i_clear_from_decode),
    .i_data_stall           (i_data_stall),
    .i_stall_from_shifter   (i_stall_from_shifter),
    .i_stall_from_issue     (i_stall_from_issue),
    .i_pipeline_dav         (i_pipeline_dav),
    .i_copro_done           (i_copro_done),
    .o_instruction          (o_instruction),
    .o_valid                (o_valid),
    .o_und                  (o_und),
    .o_irq                  (o_irq),
    .o_fiq                  (o_fiq),
    .o_stall_from_decode    (o_stall_from_decode),
    .o_copro_dav_nxt        (o_copro_dav_nxt),
    .o_copro_word_nxt       (o_copro_word_nxt),
    .o_copro_timeout        (o_copro_timeout)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: which coprocessor owns the pending request (-1 none), trap pending,
  // BUSY cycles spent, latched word and the registered timeout pulse.
  int          m_cp   = -1;
  bit          m_trap = 1'b0;
  int          m_el   = 0;
  logic [31:0] m_word = '0;
  bit          m_to   = 1'b0;
  bit          s_stall, s_to;

  task automatic chk(input string tag, input logic [34:0] act, input logic [34:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic bit m_is_cop(input logic [34:0] ins, input bit v, input bit t);
    int unsigned w;
    w = ins[31:0];
    return v && !t && (ins[34:32] == 3'b000) &&
           ((((w >> 25) & 7) == 6) || (((w >> 24) & 15) == 14));
  endfunction

  task automatic step();
    bit ext, flush, legal, e_stall, e_und, e_mask, n_trap, n_to;
    int cp, n_cp, n_el;
    logic [15:0] e_dav;
    logic [31:0] e_word, n_word;
    @(negedge i_clk);
    ext   = i_data_stall | i_stall_from_shifter | i_stall_from_issue;
    flush = i_clear_from_writeback | (i_clear_from_alu & !i_data_stall) | (i_clear_from_decode & !ext);
    cp    = int'(i_instruction[11:8]);
    legal = PRESENT[cp] && (i_cpsr_ff_mode != USR || USRM[cp]);
    e_dav = (m_cp >= 0) ? 16'(1 << m_cp) : 16'h0;
    e_word = m_word;
    e_stall = 0; e_und = 0; e_mask = 0;
    n_cp = m_cp; n_trap = m_trap; n_el = m_el; n_word = m_word; n_to = 0;
    if (m_trap) begin
      e_und = 1; e_mask = 1;
      if (!ext) n_trap = 0;
    end else if (m_cp >= 0) begin
      e_stall = 1; e_mask = 1;
      if (!ext && i_copro_done[m_cp]) begin
        e_stall = 0; n_cp = -1; n_word = '0; e_dav = '0; e_word = '0;
      end else if (!ext && m_el == TO - 1) begin
        n_to = 1; n_cp = -1; n_trap = 1; e_dav = '0;
      end else if (!ext) begin
        n_el = m_el + 1;
      end
    end else if (m_is_cop(i_instruction, i_valid, i_cpsr_ff_t)) begin
      e_stall = 1; e_mask = 1;
      if (!legal) begin
        if (!ext) n_trap = 1;
      end else if (!i_pipeline_dav && !ext) begin
        n_cp = cp; n_el = 0; n_word = i_instruction[31:0];
        e_dav = 16'(1 << cp); e_word = i_instruction[31:0];
      end
    end
    if (flush) begin
      e_stall = 0; e_und = 0; e_dav = '0; e_word = m_word;
      n_cp = -1; n_trap = 0; n_el = 0; n_word = m_word; n_to = 0;
    end
    if (!i_reset_n) begin
      e_stall = 0; e_und = 0; e_mask = 0; e_dav = '0; e_word = '0;
      n_cp = -1; n_trap = 0; n_el = 0; n_word = '0; n_to = 0;
    end
    chk("dav_nxt", 35'(o_copro_dav_nxt), 35'(e_dav));
    chk("word_nxt", 35'(o_copro_word_nxt), 35'(e_word));
    chk("stall", 35'(o_stall_from_decode), 35'(e_stall));
    chk("und", 35'(o_und), 35'(e_und));
    chk("irq", 35'(o_irq), 35'(i_irq & !e_mask));
    chk("fiq", 35'(o_fiq), 35'(i_fiq & !e_mask));
    chk("valid", 35'(o_valid), 35'(i_valid));
    chk("instr", o_instruction, i_instruction);
    chk("timeout", 35'(o_copro_timeout), 35'(m_to));
    s_stall = o_stall_from_decode;
    s_to    = o_copro_timeout;
    m_cp = n_cp; m_trap = n_trap; m_el = n_el; m_word = n_word; m_to = n_to;
    @(posedge i_clk);
    #1;
  endtask

  task automatic quiet();
    i_reset_n = 1; i_valid = 0; i_cpsr_ff_t = 0; i_cpsr_ff_mode = SVC;
    i_irq = 0; i_fiq = 0; i_instruction = '0;
    i_clear_from_writeback = 0; i_clear_from_alu = 0; i_clear_from_decode = 0;
    i_data_stall = 0; i_stall_from_shifter = 0; i_stall_from_issue = 0;
    i_pipeline_dav = 0; i_copro_done = '0;
  endtask

  task automatic drain();
    quiet();
    repeat (2) step();
  endtask

  function automatic logic [34:0] rand_instr();
    logic [31:0] w;
    logic [2:0]  hi;
    w = $urandom;
    case ($urandom_range(0, 3))
      0:       w[27:25] = 3'b110;
      1, 2:    w[27:24] = 4'b1110;
      default: ;
    endcase
    case ($urandom_range(0, 4))
      0:       w[11:8] = 4'hF;
      1:       w[11:8] = 4'hD;
      2:       w[11:8] = 4'h0;
      3:       w[11:8] = 4'hE;
      default: ;
    endcase
    hi = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
    return {hi, w};
  endfunction

  initial begin
    int nst, nto;
    quiet();
    i_reset_n = 0;
    repeat (2) @(posedge i_clk);
    #1;
    step();
    i_reset_n = 1;
    step();

    // MRC p15 in SVC, done on the fourth BUSY cycle; interrupts must stay masked.
    i_instruction = {3'b000, 32'hEE11_0F10}; i_valid = 1; i_irq = 1; i_fiq = 1;
    nst = 0;
    for (int k = 0; k < 5; k++) begin
      i_copro_done = (k == 4) ? 16'h8000 : 16'h0000;
      step();
      if (s_stall) nst++;
    end
    chk("mrc_stall_cycles", 35'(nst), 35'd4);
    drain();

    // MCR p15 in USR (not user-accessible), then CDP p14 (absent).
    i_instruction = {3'b000, 32'hEE01_0F10}; i_valid = 1; i_cpsr_ff_mode = USR;
    step(); step();
    drain();
    i_instruction = {3'b000, 32'hEE00_0E00}; i_valid = 1;
    step(); step();
    drain();

    // No done: TIMEOUT BUSY cycles, one timeout pulse, then the trap cycle.
    i_instruction = {3'b000, 32'hEE11_0F10}; i_valid = 1;
    nto = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (s_to) nto++;
    end
    i_valid = 0;
    for (int k = 0; k < 2; k++) begin
      step();
      if (s_to) nto++;
    end
    chk("timeout_pulses", 35'(nto), 35'd1);
    drain();

    // Wrong coprocessor's done is ignored, the right one completes.
    i_instruction = {3'b000, 32'hEE11_0F10}; i_valid = 1;
    step();
    i_copro_done = 16'h4000; step();
    i_copro_done = 16'h8000; step();
    drain();

    // Writeback clear mid-BUSY, then reset mid-BUSY.
    i_instruction = {3'b000, 32'hEE11_0F10}; i_valid = 1;
    step(); step();
    i_clear_from_writeback = 1; step();
    drain();
    i_instruction = {3'b000, 32'hEE11_0F10}; i_valid = 1;
    step(); step();
    i_reset_n = 0; step();
    drain();

    for (int n = 0; n < 3000; n++) begin
      if (!(s_stall && $urandom_range(0, 3) != 0)) begin
        i_instruction = rand_instr();
        i_valid       = ($urandom_range(0, 5) != 0);
        i_cpsr_ff_t   = ($urandom_range(0, 15) == 0);
        i_cpsr_ff_mode = ($urandom_range(0, 1) == 0) ? USR : SVC;
      end
      i_reset_n              = ($urandom_range(0, 299) != 0);
      i_irq                  = 1'($urandom);
      i_fiq                  = 1'($urandom);
      i_pipeline_dav         = ($urandom_range(0, 2) == 0);
      i_data_stall           = ($urandom_range(0, 19) == 0);
      i_stall_from_shifter   = ($urandom_range(0, 19) == 0);
      i_stall_from_issue     = ($urandom_range(0, 19) == 0);
      i_clear_from_writeback = ($urandom_range(0, 49) == 0);
      i_clear_from_alu       = ($urandom_range(0, 49) == 0);
      i_clear_from_decode    = ($urandom_range(0, 49) == 0);
      case ($urandom_range(0, 7))
        0, 1:    i_copro_done = (m_cp >= 0) ? 16'(1 << m_cp) : 16'h0;
        2:       i_copro_done = 16'($urandom);
        default: i_copro_done = 16'h0;
      endcase
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
